reg_write_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit D flip-flop register between N_REQ requesters. Each requester raises a write request with its data. The arbiter grants one requester at a time, loads that requester's data into the shared register, and returns a one-cycle acknowledge. It sits in front of the shared register bank and is the only path that writes to it.

---
 rtl/reg_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter in front of one shared WIDTH-bit
// register. One requester is granted at a time; its data is loaded during
// WRITE and a one-cycle acknowledge follows in ACK. All outputs are registered.
module reg_write_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic                   busy,
  output logic [IDX_W-1:0]       last_owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0] NONE     = {N_REQ{1'b0}};

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  winner_s;

  // First requesting index found when scanning upward from ptr with wrap.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                   input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && r[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign winner_s   = pick_winner(req, rr_ptr_q);
  assign grant      = grant_q;
  assign ack        = ack_q;
  assign q          = data_q;
  assign q_valid    = valid_q;
  assign busy       = busy_q;
  assign last_owner = last_q;

  // Next-state and registered-output logic for the IDLE/WRITE/ACK sequence.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    grant_d  = grant_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        ack_d = NONE;
        if (|req) begin
          owner_d = winner_s;
          grant_d = ONE_HOT0 << winner_s;
          busy_d  = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        grant_d = NONE;
        if (req[owner_q]) begin
          // Requester still holding its request: commit the write.
          data_d  = wdata[int'(owner_q)*WIDTH +: WIDTH];
          valid_d = 1'b1;
          last_d  = owner_q;
          ack_d   = ONE_HOT0 << owner_q;
          state_d = ST_ACK;
        end else begin
          // Request withdrawn: abort without writing or moving the pointer.
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        ack_d    = NONE;
        busy_d   = 1'b0;
        rr_ptr_d = IDX_W'((int'(owner_q) + 1) % N_REQ);
        state_d  = ST_IDLE;
      end
      default: begin
        grant_d = NONE;
        ack_d   = NONE;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset discards any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= {IDX_W{1'b0}};
      rr_ptr_q <= {IDX_W{1'b0}};
      data_q   <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
      grant_q  <= NONE;
      ack_q    <= NONE;
      busy_q   <= 1'b0;
      last_q   <= {IDX_W{1'b0}};
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter (N_REQ=4, WIDTH=8): directed scenarios plus
// randomized, protocol-respecting requesters checked against a transaction model.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   grant, ack;
  logic [W-1:0]   q;
  logic           q_valid, busy;
  logic [1:0]     last_owner;
  logic [19:0]    obs;

  int vectors = 0;
  int miscompares = 0;

  // Model of the arbiter's observable behaviour.
  int          m_stage;   // 0 = waiting for requests, 1 = granted, 2 = acknowledging
  int          m_owner, m_ptr, m_last;
  logic [N-1:0] m_grant, m_ack;
  logic [W-1:0] m_q;
  logic         m_valid, m_busy;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant), .ack(ack), .q(q), .q_valid(q_valid),
    .busy(busy), .last_owner(last_owner)
  );

  always #5 clk = ~clk;

  assign obs = {grant, ack, q, q_valid, busy, last_owner};

  function automatic logic [19:0] mdl_vec();
    return {m_grant, m_ack, m_q, m_valid, m_busy, 2'(m_last)};
  endfunction

  task automatic mdl_reset();
    m_stage = 0; m_owner = 0; m_ptr = 0; m_last = 0;
    m_grant = '0; m_ack = '0; m_q = '0; m_valid = 1'b0; m_busy = 1'b0;
  endtask

  // One clock edge of the model, given the inputs present at that edge.
  task automatic mdl_edge(input logic [N-1:0] r, input logic [N*W-1:0] wd);
    if (m_stage == 0) begin
      m_ack = '0;
      if (r != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_grant = '0;
        m_grant[m_owner] = 1'b1;
        m_busy  = 1'b1;
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      m_grant = '0;
      if (r[m_owner]) begin
        m_q     = wd[m_owner*W +: W];
        m_valid = 1'b1;
        m_last  = m_owner;
        m_ack[m_owner] = 1'b1;
        m_stage = 2;
      end else begin
        m_busy  = 1'b0;
        m_stage = 0;
      end
    end else begin
      m_ack   = '0;
      m_busy  = 1'b0;
      m_ptr   = (m_owner + 1) % N;
      m_stage = 0;
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples.
  task automatic tick();
    logic [N-1:0]   r;
    logic [N*W-1:0] wd;
    r  = req;
    wd = wdata;
    @(posedge clk);
    if (reset) mdl_edge(r, wd);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    mdl_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b1111;
    wdata = {$urandom, $urandom} & 32'hFFFF_FFFF;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 20'h0_0000) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", obs, 20'h0_0000);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (obs !== mdl_vec() || grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_release_grant: got %h expected %h", obs, mdl_vec());
    end
    // Fresh start, then reset in the middle of WRITE.
    apply_reset();
    req = 4'b0010;
    tick();
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL midwrite_grant: got %b expected %b", grant, 4'b0010);
    end
    #2;
    reset = 1'b0;
    mdl_reset();
    #1;
    vectors++;
    if ({grant, ack, q, q_valid, busy} !== {4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midwrite_async_reset: got g=%b a=%b q=%h v=%b b=%b expected all zero",
               grant, ack, q, q_valid, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== 20'h0_0000) begin
      miscompares++;
      $display("FAIL midwrite_no_ack: got %h expected %h", obs, 20'h0_0000);
    end
    reset = 1'b1;
    req   = '0;
  endtask

  task automatic test_single_write();
    apply_reset();
    wdata = 32'h00A5_0000;
    req   = 4'b0100;
    tick();
    vectors++;
    if (obs !== mdl_vec() || grant !== 4'b0100 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: got %h expected %h", obs, mdl_vec());
    end
    tick();
    req = 4'b0000;
    vectors++;
    if (obs !== mdl_vec() ||
        {grant, ack, q, q_valid, busy, last_owner} !== {4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b1, 2'd2}) begin
      miscompares++;
      $display("FAIL single_ack: got %h expected %h", obs, {4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b1, 2'd2});
    end
    tick();
    vectors++;
    if (obs !== mdl_vec() ||
        {grant, ack, q, q_valid, busy, last_owner} !== {4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, 2'd2}) begin
      miscompares++;
      $display("FAIL single_idle: got %h expected %h", obs, {4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, 2'd2});
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [7:0] qs[$];
    apply_reset();
    wdata = 32'h1312_1110;
    req   = 4'b1111;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      tick();
      vectors++;
      if (obs !== mdl_vec()) begin
        miscompares++;
        $display("FAIL rr_cycle %0d: got %h expected %h", c, obs, mdl_vec());
      end
      for (int i = 0; i < N; i++)
        if (ack[i]) begin
          order.push_back(i);
          qs.push_back(q);
        end
      req = 4'b1111 & ~ack;
    end
    vectors++;
    if (order.size() != 5) begin
      miscompares++;
      $display("FAIL rr_timeout: got %0d acks expected 5", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      vectors++;
      if (order[i] != i % N || qs[i] !== 8'(8'h10 + i % N)) begin
        miscompares++;
        $display("FAIL rr_order %0d: got owner %0d q %h expected owner %0d q %h",
                 i, order[i], qs[i], i % N, 8'(8'h10 + i % N));
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_priority();
    apply_reset();
    wdata = 32'h4433_2211;
    req   = 4'b0010;
    tick();
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();
    vectors++;
    if (obs !== mdl_vec() || grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL priority_after_move: got grant %b expected %b", grant, 4'b0001);
    end
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] saved;
    apply_reset();
    wdata = 32'h5D00_00C3;
    req   = 4'b0001;
    tick();
    tick();
    req = 4'b0000;
    tick();
    saved = q;
    req = 4'b1000;
    tick();
    vectors++;
    if (grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL abort_grant: got %b expected %b", grant, 4'b1000);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (obs !== mdl_vec() || {grant, ack, q, busy} !== {4'b0000, 4'b0000, saved, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_no_write: got %h expected %h", obs, mdl_vec());
    end
    req = 4'b1000;
    tick();
    vectors++;
    if (grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL abort_rerequest: got %b expected %b", grant, 4'b1000);
    end
    // Abort again; pointer must still point at 1 so 3 beats 0.
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    vectors++;
    if (obs !== mdl_vec() || grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL abort_ptr_kept: got grant %b expected %b", grant, 4'b1000);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_late_request();
    apply_reset();
    wdata = 32'h0000_2A17;
    req   = 4'b0001;
    tick();
    tick();
    vectors++;
    if (ack !== 4'b0001) begin
      miscompares++;
      $display("FAIL late_ack0: got %b expected %b", ack, 4'b0001);
    end
    req = 4'b0010;
    tick();
    vectors++;
    if (obs !== mdl_vec() || grant !== 4'b0000 || ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL late_ack_one_cycle: got g=%b a=%b expected 0000 0000", grant, ack);
    end
    tick();
    vectors++;
    if (obs !== mdl_vec() || grant !== 4'b0010 || ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL late_grant1: got g=%b a=%b expected 0010 0000", grant, ack);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    wdata = {$urandom} & 32'hFFFF_FFFF;
    for (int c = 0; c < 800; c++) begin
      tick();
      vectors++;
      if (obs !== mdl_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h expected %h", c, obs, mdl_vec());
      end
      vectors++;
      if ((grant & ack) !== 4'b0000 || !$onehot0(grant) || !$onehot0(ack)) begin
        miscompares++;
        $display("FAIL random_invariant cycle %0d: got g=%b a=%b expected one-hot, disjoint",
                 c, grant, ack);
      end
      for (int i = 0; i < N; i++) begin
        if (m_grant[i]) begin
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if (m_ack[i]) begin
          req[i] = 1'b0;
        end else begin
          req[i] = ($urandom_range(0, 2) != 0);
          wdata[i*W +: W] = 8'($urandom);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    wdata = '0;
    mdl_reset();
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_priority();
    test_abort();
    test_late_request();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
